// File: rtl/stdcore_pkg.sv
// Shared types and helpers for the stdcore streaming blocks.
package stdcore_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Modular add for operands already reduced below n.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/stdcore_rrpick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping mod N.
module stdcore_rrpick
    import stdcore_pkg::*;
#(
    parameter int N  = 4,
    parameter int NW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [NW-1:0] ptr,
    output logic          found,
    output logic [NW-1:0] idx
);

    always_comb begin
        int unsigned j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = wrap_add(int'(ptr), k, N);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = NW'(j);
            end
        end
    end

endmodule

// File: rtl/stdcore_rrarb.sv
// Packet-aware round-robin arbiter feeding a single registered output slot.
module stdcore_rrarb
    import stdcore_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int NW = 2
) (
    input  logic            clk,
    input  logic            arst,
    input  logic [N*DW-1:0] p,
    input  logic [N-1:0]    p_val,
    input  logic [N-1:0]    p_last,
    output logic [N-1:0]    p_rdy,
    output logic [DW-1:0]   c,
    output logic            c_val,
    output logic            c_last,
    output logic [NW-1:0]   c_src,
    input  logic            c_rdy
);

    state_t          state_q, state_d;
    logic [NW-1:0]   owner_q, owner_d;
    logic [NW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   c_q, c_d;
    logic            c_val_q, c_val_d;
    logic            c_last_q, c_last_d;
    logic [NW-1:0]   c_src_q, c_src_d;

    logic            pick_found;
    logic [NW-1:0]   pick_idx;
    logic [NW-1:0]   sel;
    logic            sel_ok;
    logic            slot_free;
    logic            xfer;

    stdcore_rrpick #(
        .N  (N),
        .NW (NW)
    ) u_pick (
        .req   (p_val),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        slot_free = !c_val_q || c_rdy;
        if (state_q == ST_LOCK) begin
            sel    = owner_q;
            sel_ok = p_val[owner_q];
        end else begin
            sel    = pick_idx;
            sel_ok = pick_found;
        end
        xfer  = sel_ok && slot_free;
        p_rdy = '0;
        if (sel_ok) begin
            p_rdy[sel] = slot_free;
        end

        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        c_d      = c_q;
        c_val_d  = c_val_q;
        c_last_d = c_last_q;
        c_src_d  = c_src_q;

        if (xfer) begin
            c_d      = p[sel*DW +: DW];
            c_last_d = p_last[sel];
            c_src_d  = sel;
            c_val_d  = 1'b1;
            // Last beat releases the lock from either state; ptr moves only here.
            if (p_last[sel]) begin
                state_d = ST_IDLE;
                ptr_d   = NW'(wrap_add(int'(sel), 1, N));
            end else if (state_q == ST_IDLE) begin
                state_d = ST_LOCK;
                owner_d = sel;
            end
        end else if (c_rdy) begin
            c_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            c_q      <= '0;
            c_val_q  <= 1'b0;
            c_last_q <= 1'b0;
            c_src_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            c_q      <= c_d;
            c_val_q  <= c_val_d;
            c_last_q <= c_last_d;
            c_src_q  <= c_src_d;
        end
    end

    assign c      = c_q;
    assign c_val  = c_val_q;
    assign c_last = c_last_q;
    assign c_src  = c_src_q;

endmodule

// File: tb/tb_stdcore_rrarb.sv
// Directed bench for stdcore_rrarb with hand-computed expectations.
module tb_stdcore_rrarb;
    import stdcore_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int NW = 2;

    logic            clk;
    logic            arst;
    logic [N*DW-1:0] p;
    logic [N-1:0]    p_val;
    logic [N-1:0]    p_last;
    logic [N-1:0]    p_rdy;
    logic [DW-1:0]   c;
    logic            c_val;
    logic            c_last;
    logic [NW-1:0]   c_src;
    logic            c_rdy;

    int n_chk;
    int n_pass;

    stdcore_rrarb #(
        .N  (N),
        .DW (DW),
        .NW (NW)
    ) dut (
        .clk    (clk),
        .arst   (arst),
        .p      (p),
        .p_val  (p_val),
        .p_last (p_last),
        .p_rdy  (p_rdy),
        .c      (c),
        .c_val  (c_val),
        .c_last (c_last),
        .c_src  (c_src),
        .c_rdy  (c_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        p[i*DW +: DW] = d;
    endtask

    task automatic chk_out(input string tag, input logic [NW-1:0] src,
                           input logic [DW-1:0] d, input logic last);
        chk({tag, "_val"},  32'(c_val),  32'd1);
        chk({tag, "_src"},  32'(c_src),  32'(src));
        chk({tag, "_data"}, 32'(c),      32'(d));
        chk({tag, "_last"}, 32'(c_last), 32'(last));
    endtask

    initial begin
        int e;
        n_chk = 0;
        n_pass = 0;
        arst = 1'b1;
        p = '0;
        c_rdy = 1'b1;
        p_val = 4'b1111;
        p_last = 4'b1111;
        for (int i = 0; i < N; i++) set_data(i, 8'(i << 4));

        // Reset with all requesters valid
        repeat (2) tick();
        chk("rst_c_val", 32'(c_val), 32'd0);
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_c_src", 32'(c_src), 32'd0);
        chk("rst_c_last", 32'(c_last), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        #2 arst = 1'b0;

        // Round robin, single-beat packets back to back
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_rdy", 32'(p_rdy), 32'(1) << (k % 4));
            tick();
            chk_out("rr", NW'(k % 4), 8'((k % 4) << 4), 1'b1);
        end
        p_val = '0;
        tick();
        chk("rr_drain_val", 32'(c_val), 32'd0);

        // Lock: requester 1 sends 3 beats while requester 2 waits
        set_data(1, 8'h10);
        set_data(2, 8'h20);
        p_last = 4'b0100;
        p_val = 4'b0110;
        #2 chk("lk_rdy0", 32'(p_rdy), 32'b0010);
        tick();
        chk_out("lk_b0", 2'd1, 8'h10, 1'b0);
        set_data(1, 8'h11);
        #2 chk("lk_rdy1", 32'(p_rdy), 32'b0010);
        tick();
        chk_out("lk_b1", 2'd1, 8'h11, 1'b0);
        p_val = 4'b0100;
        #2 chk("lk_stall_rdy", 32'(p_rdy), 32'b0000);
        tick();
        chk("lk_stall_val", 32'(c_val), 32'd0);
        p_val = 4'b0110;
        p_last = 4'b0110;
        set_data(1, 8'h12);
        #2 chk("lk_rdy2", 32'(p_rdy), 32'b0010);
        tick();
        chk_out("lk_b2", 2'd1, 8'h12, 1'b1);
        p_val = 4'b0100;
        #2 chk("lk_rdy_r2", 32'(p_rdy), 32'b0100);
        tick();
        chk_out("lk_r2", 2'd2, 8'h20, 1'b1);
        p_val = '0;
        tick();

        // Backpressure mid-packet from requester 3 (ptr = 3)
        set_data(3, 8'h30);
        p_last = 4'b0000;
        p_val = 4'b1000;
        #2 chk("bp_rdy0", 32'(p_rdy), 32'b1000);
        tick();
        chk_out("bp_b0", 2'd3, 8'h30, 1'b0);
        set_data(3, 8'h31);
        p_last = 4'b1000;
        c_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2 chk("bp_hold_rdy", 32'(p_rdy), 32'b0000);
            tick();
            chk_out("bp_hold", 2'd3, 8'h30, 1'b0);
        end
        c_rdy = 1'b1;
        #2 chk("bp_rdy1", 32'(p_rdy), 32'b1000);
        tick();
        chk_out("bp_b1", 2'd3, 8'h31, 1'b1);
        p_val = '0;
        tick();
        chk("bp_drain_val", 32'(c_val), 32'd0);

        // Wrap: move ptr to 3, then requesters 0 and 3 alternate
        set_data(2, 8'h22);
        p_last = 4'b1111;
        p_val = 4'b0100;
        #2 chk("wr_rdy_r2", 32'(p_rdy), 32'b0100);
        tick();
        chk_out("wr_r2", 2'd2, 8'h22, 1'b1);
        set_data(0, 8'h01);
        set_data(3, 8'h33);
        p_val = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            e = (k % 2 == 0) ? 3 : 0;
            #2 chk("wr_rdy", 32'(p_rdy), 32'(1) << e);
            tick();
            chk_out("wr", NW'(e), (e == 3) ? 8'h33 : 8'h01, 1'b1);
        end
        p_val = '0;
        tick();

        // Reset during beat 2 of a 4-beat packet from requester 2 (ptr = 1)
        set_data(2, 8'h24);
        p_last = 4'b0000;
        p_val = 4'b0100;
        #2 chk("mr_rdy0", 32'(p_rdy), 32'b0100);
        tick();
        chk_out("mr_b0", 2'd2, 8'h24, 1'b0);
        set_data(2, 8'h25);
        #2 arst = 1'b1;
        #1;
        chk("mr_c_val", 32'(c_val), 32'd0);
        chk("mr_state", 32'(dut.state_q), 32'(ST_IDLE));
        tick();
        #2 arst = 1'b0;
        set_data(0, 8'h02);
        p_last = 4'b1111;
        p_val = 4'b0101;
        #1 chk("mr_rdy_r0", 32'(p_rdy), 32'b0001);
        tick();
        chk_out("mr_r0", 2'd0, 8'h02, 1'b1);
        p_val = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stdcore_rrarb.md
STDCORE_RRARB -- requirements
Module: stdcore_rrarb

Interface
REQ-001 Parameter N, default 4, number of requesters (2..16).
REQ-002 Parameter DW, default 8, data width per beat.
REQ-003 Parameter NW, default 2, requester index width; SHALL satisfy 2^NW >= N.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 arst  input  1  reset, asynchronous, active-high.
REQ-006 p  input  N*DW  requester data; requester i occupies bits [i*DW +: DW].
REQ-007 p_val  input  N  per-requester beat valid.
REQ-008 p_last  input  N  per-requester last-beat-of-packet flag; qualified by p_val.
REQ-009 p_rdy  output  N  per-requester ready; beat i transfers when p_val[i] and p_rdy[i] are both high.
REQ-010 c  output  DW  granted beat data, registered.
REQ-011 c_val  output  1  output beat valid, registered.
REQ-012 c_last  output  1  output last flag, registered.
REQ-013 c_src  output  NW  index of the requester that sourced the current output beat, registered.
REQ-014 c_rdy  input  1  downstream ready, typically the p_rdy of a stdcore_rfifo.

Function
REQ-015 Output stage is a single register slot; slot_free = !c_val || c_rdy.
REQ-016 States: IDLE (no packet owner) and LOCK (owner register holds the requester index).
REQ-017 IDLE: sel = the first i with p_val[i] high, searching ptr, ptr+1, ... mod N; no p_val high -> no selection.
REQ-018 LOCK: sel = owner, and only if p_val[owner] is high; all other requesters are ignored.
REQ-019 p_rdy[sel] = slot_free; every other p_rdy bit = 0; at most one p_rdy bit is high per cycle.
REQ-020 On a transfer, the next edge loads c <- p[sel], c_last <- p_last[sel], c_src <- sel, c_val <- 1; latency from p to c is 1 cycle.
REQ-021 No transfer and c_rdy high -> c_val <- 0; no transfer and c_rdy low -> c, c_val, c_last and c_src hold.
REQ-022 Transfer with p_last = 0 in IDLE -> LOCK, owner <- sel.
REQ-023 Transfer with p_last = 1 in either state -> IDLE, ptr <- (sel+1) mod N; ptr wraps from N-1 to 0.
REQ-024 A single-beat packet (p_last = 1 on the first beat) SHALL not enter LOCK.
REQ-025 ptr SHALL change only on a last-beat transfer.
REQ-026 A simultaneous downstream pop (c_rdy) and new transfer in the same cycle SHALL sustain 1 beat/cycle with no bubble.
REQ-027 In LOCK with p_val[owner] low, no beat transfers and LOCK holds indefinitely; there is no timeout.
REQ-028 A requester SHALL NOT be starved: after at most N-1 other packets it wins arbitration.
REQ-029 p_rdy may depend combinationally on p_val and c_rdy; c, c_val, c_last and c_src SHALL have no combinational path from inputs.

Reset
REQ-030 While arst is high: c_val = 0, c_last = 0, c = 0, c_src = 0, state = IDLE, ptr = 0, owner = 0.
REQ-031 Because c_val = 0 during reset and p_rdy is derived from the registered slot state, p_rdy SHALL be 0 except where REQ-019 allows it.
REQ-032 Reset asserted mid-packet SHALL discard the packet; after release, arbitration restarts from requester 0 in IDLE.

Structure
REQ-033 Shared package stdcore_pkg SHALL hold the state encodings (ST_IDLE = 0, ST_LOCK = 1).
REQ-034 The rotating-priority search SHALL be one combinational sub-module, stdcore_rrpick (inputs: N request bits, NW-bit ptr; outputs: found, NW-bit index).
REQ-035 There SHALL be no other sub-modules and no storage beyond the single output slot.

Verification
REQ-036 Reset: arst = 1 with p_val = 4'b1111 -> c_val = 0 and state = IDLE; first beat after release comes from requester 0.
REQ-037 Round-robin: all four requesters send 1-beat packets continuously, c_rdy = 1 -> c_src sequence 0,1,2,3,0,... at 1 beat/cycle.
REQ-038 Lock: requester 1 sends a 3-beat packet while requester 2 is valid -> c_src = 1,1,1, then 2; p_rdy[2] = 0 throughout the lock.
REQ-039 Backpressure: c_rdy = 0 for 5 cycles mid-packet -> c, c_src and c_last stable; exactly one beat accepted, no loss or duplication.
REQ-040 Wrap/starvation: ptr = 3, only requesters 0 and 3 valid -> grants 3, 0, 3, 0 across packets.
REQ-041 Mid-packet reset: arst pulsed during beat 2 of a 4-beat packet from requester 2 -> c_val = 0, IDLE; requester 0 packet is granted first after release.
